// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, fetches words over a req/ready
// handshake, and loads the IF/ID register. Redirects from decode squash the
// word in flight; a redirect that arrives while memory is busy parks its
// target in pending_pc until the outstanding request drains.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic [1:0]  PC_source,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic [31:0] jr_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] pc,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid
);

  typedef enum logic [1:0] {StIdle, StReq, StDrain} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pending_pc_q, pending_pc_d;
  logic        req_q, req_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;

  logic [31:0] pc_plus4;
  logic        redirect;
  logic [31:0] target;

  assign pc_plus4 = pc_q + 32'd4;
  assign redirect = !stall && (PC_source == 2'b11 || PC_source == 2'b10 || branch_taken);

  // Redirect target; JR wins over J, J over a taken branch.
  always_comb begin
    target = branch_target;
    if (PC_source == 2'b11) begin
      target = jr_target;
    end else if (PC_source == 2'b10) begin
      target = {pc4_q[31:28], instr_q[25:0], 2'b00};
    end
  end

  // Next-state logic: redirect > stall > flush > fetch.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pending_pc_d = pending_pc_q;
    req_d        = req_q;
    instr_d      = instr_q;
    pc4_d        = pc4_q;
    valid_d      = valid_q;

    unique case (state_q)
      StIdle: begin
        state_d = StReq;
        req_d   = 1'b1;
      end
      StReq: begin
        if (redirect) begin
          instr_d = '0;
          pc4_d   = '0;
          valid_d = 1'b0;
          if (imem_ready) begin
            pc_d = target;
          end else begin
            pending_pc_d = target;
            state_d      = StDrain;
          end
        end else if (stall) begin
          // Hold everything; the same address is fetched again later.
        end else if (flush) begin
          instr_d = '0;
          pc4_d   = '0;
          valid_d = 1'b0;
          if (imem_ready) begin
            pc_d = pc_plus4;
          end
        end else if (imem_ready) begin
          instr_d = imem_rdata;
          pc4_d   = pc_plus4;
          valid_d = 1'b1;
          pc_d    = pc_plus4;
        end else begin
          instr_d = '0;
          pc4_d   = '0;
          valid_d = 1'b0;
        end
      end
      StDrain: begin
        if (!stall) begin
          instr_d = '0;
          pc4_d   = '0;
          valid_d = 1'b0;
        end
        if (redirect) begin
          pending_pc_d = target;
        end
        if (imem_ready) begin
          // Drained word is dropped; the latest redirect target wins.
          pc_d    = redirect ? target : pending_pc_q;
          state_d = StReq;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // All stage state, with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      pc_q         <= RESET_PC;
      pending_pc_q <= '0;
      req_q        <= 1'b0;
      instr_q      <= '0;
      pc4_q        <= '0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pending_pc_q <= pending_pc_d;
      req_q        <= req_d;
      instr_q      <= instr_d;
      pc4_q        <= pc4_d;
      valid_q      <= valid_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign if_id_instr = instr_q;
  assign if_id_pc4   = pc4_q;
  assign if_id_valid = valid_q;

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the 5-stage MIPS pipeline. It owns the program counter, issues word fetches to instruction memory over a ready handshake, and loads the IF/ID pipeline register that feeds the decode controller. It applies PC redirects from decode: `PC_source` from the controller, plus the branch unit's `branch_taken`. It honours stall and flush from the hazard unit, and it discards fetches that are already in flight when a redirect arrives.

## Interface
- `RESET_PC`, default `32'h0000_0000`: PC value after reset.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `stall` in 1: hold PC and IF/ID; also suppresses redirects.
- `flush` in 1: load a bubble into IF/ID.
- `PC_source` in 2: decode redirect select.
  - `00`: sequential.
  - `10`: J/JAL.
  - `11`: JR.
  - `01`: unused, treated as `00`.
- `branch_taken` in 1: conditional branch resolved taken in ID.
- `branch_target` in 32: branch destination.
- `jr_target` in 32: forwarded rs value for JR.
- `imem_req` out 1: fetch request.
- `imem_addr` out 32: fetch byte address, equal to `pc`.
- `imem_rdata` in 32: instruction word; valid when `imem_ready` is high.
- `imem_ready` in 1: memory completes the current request this cycle.
- `pc` out 32: current fetch PC.
- `if_id_instr` out 32: IF/ID instruction.
- `if_id_pc4` out 32: IF/ID PC+4.
- `if_id_valid` out 1: IF/ID holds a real instruction.

## Operation
- FSM states: `IDLE`, `REQ`, `DRAIN`.
- **Reset values.** `state=IDLE`, `pc=RESET_PC`, `imem_req=0`, `if_id_instr=0`, `if_id_pc4=0`, `if_id_valid=0`, `pending_pc=0`.
- **`IDLE`.** Transitions to `REQ` on the next edge; `imem_req` is set to 1.
- **Memory protocol.**
  - `imem_addr` and `imem_req` are held stable from assertion until a cycle with `imem_ready=1`.
  - A request is never withdrawn.
  - `imem_req` stays 1 in `REQ` and `DRAIN`, including during stall.
- **Redirect condition.** `redirect = !stall && (PC_source==2'b11 || PC_source==2'b10 || branch_taken)`.
- **Redirect target priority.**
  - `11` → `jr_target`.
  - `10` → `{if_id_pc4[31:28], if_id_instr[25:0], 2'b00}`.
  - Otherwise `branch_target`.
- **Next-cycle priority:** redirect > stall > flush > fetch.
- **`REQ` state.**
  - *redirect and `imem_ready`:* fetched word discarded; `pc <= target`; IF/ID ← bubble; stay in `REQ`.
  - *redirect and `!imem_ready`:* `pending_pc <= target`; IF/ID ← bubble; go to `DRAIN`.
  - *stall:* `pc` and IF/ID hold; `imem_rdata` is ignored even if ready. The same address is re-fetched later; reads are idempotent.
  - *flush and `imem_ready`:* fetched word discarded; `pc <= pc+4`; IF/ID ← bubble.
  - *`imem_ready`:* `if_id_instr <= imem_rdata`; `if_id_pc4 <= pc+4`; `if_id_valid <= 1`; `pc <= pc+4`.
  - *otherwise:* IF/ID ← bubble; `pc` holds.
- **`DRAIN` state.**
  - Address remains the old `pc`.
  - On `imem_ready`: data discarded; `pc <= pending_pc`; go to `REQ`.
  - IF/ID holds a bubble throughout, unless stall is high, in which case it holds.
  - A new redirect in `DRAIN` overwrites `pending_pc` (latest wins).
- **Bubble.** `if_id_instr=0` (sll $0, a no-op through the controller), `if_id_pc4=0`, `if_id_valid=0`.
- **Arithmetic.** PC+4 is 32-bit modulo; `32'hFFFF_FFFC + 4 = 0`. The low two address bits are not checked.
- **Reset mid-operation.** Asserting `rst_n` low immediately forces all reset values, including from `DRAIN`. `pending_pc` is lost.

## Timing
- **Fetch throughput.** With `imem_ready` tied high: 1 instruction per cycle. IF/ID shows the word fetched at address A one cycle after `pc==A`.
- **First request.** `imem_req` rises at the first edge after reset release; the first valid IF/ID appears at the second edge.
- **Redirect penalty.** A redirect sampled at edge N sets `imem_addr=target` after edge N, provided ready was high. If not, the new address follows the edge after the drained `imem_ready`. Exactly one bubble is inserted for the squashed sequential word.
- **Combinational paths.** The redirect target is combinational from inputs to the `pc` D-input only. No combinational path from inputs to outputs.

## Test plan
1. **Reset, sequential fetch.** Reset with `RESET_PC=0`, `imem_ready=1`, memory returning `addr|0xA0000000`. → `imem_addr` 0,4,8; `if_id_instr` 0xA0000000, 0xA0000004; `if_id_pc4` 4, 8; `if_id_valid=1` from the second edge.
2. **Wait states.** `imem_ready` low for 2 cycles at `pc=8`. → `imem_addr` held at 8; two bubbles (`if_id_valid=0`, instr 0); then 0xA0000008 with pc4 = 0xC.
3. **Stall.** `stall` high for 2 cycles at `pc=0x10`. → `pc` and IF/ID frozen; no data captured; resumes with word 0x10.
4. **Taken branch.** `branch_taken=1`, `branch_target=0x100`, ready=1. → next `imem_addr=0x100`; one bubble; then `if_id_instr=0xA0000100`.
5. **JR during wait, then reset.** `PC_source=11`, `jr_target=0x200` while `imem_ready=0` at `pc=0x20`. → addr stays 0x20 until ready; that word is discarded; next addr 0x200. Repeat and assert `rst_n` low in `DRAIN`. → `pc=0`, `imem_req=0` immediately.
6. **Jump and PC wrap.** `if_id_instr=0x08000040`, `if_id_pc4=0x00000008`, `PC_source=10`. → `imem_addr=0x00000100`. Separately, with `pc=0xFFFFFFFC` → `if_id_pc4=0`, next addr 0.
